// File: rtl/lpc_cycle_decoder.sv
// Passive LPC cycle decoder: tracks host I/O and memory read/write cycles on LAD/LFRAME#
// and emits one-clock records. Define LPC_ABORT_COUNT_EN to add the out_abort_cnt counter.
module lpc_cycle_decoder #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned ENABLE_MEM   = 1,
  parameter int unsigned SYNC_TIMEOUT = 32
) (
  input  logic                  lpc_clk,
  input  logic                  lpc_reset,
  input  logic                  lpc_frame_n,
  input  logic [3:0]            lpc_ad,
  output logic                  out_valid,
  output logic                  out_mode,
  output logic                  out_direction,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [7:0]            out_data,
  output logic                  out_sync_err,
  output logic                  out_abort
`ifdef LPC_ABORT_COUNT_EN
  ,
  output logic [15:0]           out_abort_cnt
`endif
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned SR_W   = 32;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_WDATA, S_TAR1, S_SYNC, S_RDATA, S_DONE, S_TAR2, S_IGNORE
  } state_t;

  state_t            state;
  logic              mode;
  logic              dir;
  logic [SR_W-1:0]   addr_sr;
  logic [7:0]        data;
  logic [2:0]        nib_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              sync_err;
  logic [WAIT_W:0]   wait_next;
  logic              timeout_hit;

  // Wait count including the nibble being sampled now; 9 bits so saturation is visible.
  assign wait_next   = {1'b0, wait_cnt} + (WAIT_W+1)'(1);
  assign timeout_hit = (SYNC_TIMEOUT != 0) && (32'(wait_next) > SYNC_TIMEOUT);

  always_ff @(posedge lpc_clk or posedge lpc_reset) begin
    if (lpc_reset) begin
      state         <= S_IDLE;
      mode          <= 1'b0;
      dir           <= 1'b0;
      addr_sr       <= '0;
      data          <= '0;
      nib_cnt       <= '0;
      wait_cnt      <= '0;
      sync_err      <= 1'b0;
      out_valid     <= 1'b0;
      out_mode      <= 1'b0;
      out_direction <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
      out_sync_err  <= 1'b0;
      out_abort     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_abort <= 1'b0;
      if (!lpc_frame_n) begin
        // LFRAME# low overrides every state: start, host abort, or plain drop to idle.
        if (lpc_ad == 4'h0) begin
          state <= S_START;
        end else begin
          state <= S_IDLE;
          if (lpc_ad == 4'hF && state != S_IDLE && state != S_IGNORE) out_abort <= 1'b1;
        end
      end else begin
        case (state)
          S_START: begin
            dir      <= lpc_ad[1];
            addr_sr  <= '0;
            wait_cnt <= '0;
            sync_err <= 1'b0;
            if (lpc_ad[3:2] == 2'b00) begin
              mode    <= 1'b1;
              nib_cnt <= 3'd3;
              state   <= S_ADDR;
            end else if (lpc_ad[3:2] == 2'b01 && ENABLE_MEM != 0) begin
              mode    <= 1'b0;
              nib_cnt <= 3'd7;
              state   <= S_ADDR;
            end else begin
              state <= S_IGNORE;
            end
          end
          S_ADDR: begin
            addr_sr <= {addr_sr[SR_W-5:0], lpc_ad};
            nib_cnt <= nib_cnt - 3'd1;
            if (nib_cnt == 3'd0) begin
              nib_cnt <= 3'd1;
              state   <= dir ? S_WDATA : S_TAR1;
            end
          end
          S_WDATA: begin
            if (nib_cnt == 3'd1) begin
              data[3:0] <= lpc_ad;
              nib_cnt   <= 3'd0;
            end else begin
              data[7:4] <= lpc_ad;
              nib_cnt   <= 3'd1;
              state     <= S_TAR1;
            end
          end
          S_TAR1: begin
            nib_cnt <= nib_cnt - 3'd1;
            if (nib_cnt == 3'd0) state <= S_SYNC;
          end
          S_SYNC: begin
            case (lpc_ad)
              4'h0, 4'h9, 4'hA: begin
                sync_err <= (lpc_ad == 4'hA);
                if (dir) begin
                  out_valid     <= 1'b1;
                  out_mode      <= mode;
                  out_direction <= dir;
                  out_addr      <= addr_sr[ADDR_WIDTH-1:0];
                  out_data      <= data;
                  out_sync_err  <= (lpc_ad == 4'hA);
                  state         <= S_DONE;
                end else begin
                  nib_cnt <= 3'd1;
                  state   <= S_RDATA;
                end
              end
              4'h5, 4'h6: begin
                if (!wait_next[WAIT_W]) wait_cnt <= wait_next[WAIT_W-1:0];
                if (timeout_hit) begin
                  out_abort <= 1'b1;
                  state     <= S_IGNORE;
                end
              end
              default: begin
                out_abort <= 1'b1;
                state     <= S_IGNORE;
              end
            endcase
          end
          S_RDATA: begin
            if (nib_cnt == 3'd1) begin
              data[3:0] <= lpc_ad;
              nib_cnt   <= 3'd0;
            end else begin
              data[7:4]     <= lpc_ad;
              out_valid     <= 1'b1;
              out_mode      <= mode;
              out_direction <= dir;
              out_addr      <= addr_sr[ADDR_WIDTH-1:0];
              out_data      <= {lpc_ad, data[3:0]};
              out_sync_err  <= sync_err;
              state         <= S_DONE;
            end
          end
          S_DONE: begin
            nib_cnt <= 3'd1;
            state   <= S_TAR2;
          end
          S_TAR2: begin
            nib_cnt <= nib_cnt - 3'd1;
            if (nib_cnt == 3'd0) state <= S_IDLE;
          end
          S_IDLE, S_IGNORE: state <= state;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef LPC_ABORT_COUNT_EN
  // Saturating count of abandoned cycles; only reset clears it.
  always_ff @(posedge lpc_clk or posedge lpc_reset) begin
    if (lpc_reset) begin
      out_abort_cnt <= '0;
    end else if (out_abort && out_abort_cnt != 16'hFFFF) begin
      out_abort_cnt <= out_abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Self-checking bench for lpc_cycle_decoder: directed LPC cycles plus randomized transactions
// compared against a transaction-level expectation model.
module tb_lpc_cycle_decoder;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 4;

  logic          lpc_clk     = 1'b0;
  logic          lpc_reset   = 1'b1;
  logic          lpc_frame_n = 1'b1;
  logic [3:0]    lpc_ad      = 4'hF;
  logic          out_valid;
  logic          out_mode;
  logic          out_direction;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_data;
  logic          out_sync_err;
  logic          out_abort;
`ifdef LPC_ABORT_COUNT_EN
  logic [15:0]   out_abort_cnt;
`endif

  lpc_cycle_decoder #(.ADDR_WIDTH(AW), .ENABLE_MEM(1), .SYNC_TIMEOUT(TMO)) dut (
    .lpc_clk(lpc_clk), .lpc_reset(lpc_reset), .lpc_frame_n(lpc_frame_n), .lpc_ad(lpc_ad),
    .out_valid(out_valid), .out_mode(out_mode), .out_direction(out_direction),
    .out_addr(out_addr), .out_data(out_data), .out_sync_err(out_sync_err),
    .out_abort(out_abort)
`ifdef LPC_ABORT_COUNT_EN
    , .out_abort_cnt(out_abort_cnt)
`endif
  );

  always #15 lpc_clk = ~lpc_clk;

  typedef struct {
    int          cyc;
    logic        mode;
    logic        dir;
    logic [31:0] addr;
    logic [7:0]  data;
    logic        err;
  } rec_t;

  int   cyc = 0;
  int   last_drv = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   overlap = 0;
  rec_t rec_q[$];
  int   abort_q[$];

  always @(posedge lpc_clk) cyc <= cyc + 1;

  // Monitor: log every record and abort pulse with the cycle index of the edge that produced it.
  always @(negedge lpc_clk) begin
    if (out_valid === 1'b1)
      rec_q.push_back('{cyc, out_mode, out_direction, 32'(out_addr), out_data, out_sync_err});
    if (out_abort === 1'b1) abort_q.push_back(cyc);
    if (out_valid === 1'b1 && out_abort === 1'b1) overlap++;
  end

  // Drive one bus clock; last_drv is the index of the posedge that samples it.
  task automatic drive(input logic f, input logic [3:0] a);
    @(negedge lpc_clk);
    lpc_frame_n = f;
    lpc_ad      = a;
    last_drv    = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 4'hF);
  endtask

  // Expected record straight from the transaction: I/O addresses are 16-bit, zero-extended.
  function automatic logic [42:0] exp_rec(input bit io, input bit wr, input logic [31:0] a,
                                          input logic [7:0] d, input logic [3:0] rc);
    logic [31:0] ea;
    ea = io ? {16'h0, a[15:0]} : a;
    return {io, wr, ea, d, (rc == 4'hA)};
  endfunction

  function automatic logic [42:0] got_rec(input rec_t r);
    return {r.mode, r.dir, r.addr, r.data, r.err};
  endfunction

  task automatic run_cycle(input bit io, input bit wr, input logic [31:0] a, input logic [7:0] d,
                           input int waits, input logic [3:0] wcode, input logic [3:0] rcode,
                           output int done_cyc);
    drive(1'b0, 4'h0);
    drive(1'b1, {1'b0, ~io, wr, 1'b0});
    for (int n = (io ? 3 : 7); n >= 0; n--) drive(1'b1, a[4*n +: 4]);
    if (wr) begin drive(1'b1, d[3:0]); drive(1'b1, d[7:4]); end
    repeat (2) drive(1'b1, 4'($urandom));
    repeat (waits) drive(1'b1, wcode);
    drive(1'b1, rcode);
    if (!wr) begin drive(1'b1, d[3:0]); drive(1'b1, d[7:4]); end
    done_cyc = last_drv;
  endtask

  task automatic test_reset();
    lpc_reset = 1'b1;
    repeat (3) @(negedge lpc_clk);
    n_checks++; if ({out_valid, out_abort, out_mode, out_direction, out_sync_err} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {out_valid, out_abort, out_mode, out_direction, out_sync_err}); else n_pass++;
    n_checks++; if ({out_addr, out_data} !== '0)
      $display("FAIL reset_fields: got addr=%h data=%h want 0", out_addr, out_data); else n_pass++;
    lpc_reset = 1'b0;
    idle(4);
    n_checks++; if (rec_q.size() + abort_q.size() != 0)
      $display("FAIL reset_quiet: got %0d events want 0", rec_q.size() + abort_q.size()); else n_pass++;
  endtask

  task automatic test_io_write();
    int dc; rec_t r;
    rec_q.delete(); abort_q.delete();
    run_cycle(1'b1, 1'b1, 32'h0080, 8'h5A, 0, 4'h6, 4'h0, dc);
    idle(3);
    n_checks++; if (rec_q.size() != 1) $display("FAIL io_write_count: got %0d want 1", rec_q.size()); else n_pass++;
    if (rec_q.size() > 0) r = rec_q[0];
    n_checks++; if (got_rec(r) !== {1'b1, 1'b1, 32'h0000_0080, 8'h5A, 1'b0})
      $display("FAIL io_write_rec: got %h want %h", got_rec(r), {1'b1, 1'b1, 32'h0000_0080, 8'h5A, 1'b0}); else n_pass++;
    n_checks++; if (r.cyc !== dc) $display("FAIL io_write_latency: got cyc %0d want %0d", r.cyc, dc); else n_pass++;
  endtask

  task automatic test_mem_read();
    int dc; rec_t r;
    rec_q.delete(); abort_q.delete();
    run_cycle(1'b0, 1'b0, 32'hFFFF_FFF0, 8'hC3, 3, 4'h5, 4'h0, dc);
    idle(3);
    n_checks++; if (rec_q.size() != 1) $display("FAIL mem_read_count: got %0d want 1", rec_q.size()); else n_pass++;
    if (rec_q.size() > 0) r = rec_q[0];
    n_checks++; if (r.addr !== 32'hFFFF_FFF0) $display("FAIL mem_read_addr: got %h want FFFFFFF0", r.addr); else n_pass++;
    n_checks++; if ({r.mode, r.dir, r.data, r.err} !== {2'b00, 8'hC3, 1'b0})
      $display("FAIL mem_read_fields: got %b want %b", {r.mode, r.dir, r.data, r.err}, {2'b00, 8'hC3, 1'b0}); else n_pass++;
    n_checks++; if (r.cyc !== dc) $display("FAIL mem_read_latency: got cyc %0d want %0d", r.cyc, dc); else n_pass++;
    n_checks++; if (abort_q.size() != 0) $display("FAIL mem_read_abort: got %0d want 0", abort_q.size()); else n_pass++;
  endtask

  task automatic test_sync_err();
    int dc; rec_t r;
    rec_q.delete(); abort_q.delete();
    run_cycle(1'b1, 1'b0, 32'h0060, 8'hFF, 0, 4'h6, 4'hA, dc);
    idle(3);
    if (rec_q.size() > 0) r = rec_q[0];
    n_checks++; if (rec_q.size() != 1 || got_rec(r) !== {1'b1, 1'b0, 32'h60, 8'hFF, 1'b1})
      $display("FAIL sync_err_rec: got n=%0d %h want n=1 %h", rec_q.size(), got_rec(r), {1'b1, 1'b0, 32'h60, 8'hFF, 1'b1}); else n_pass++;
  endtask

  task automatic test_abort();
    int ac;
    rec_q.delete(); abort_q.delete();
    drive(1'b0, 4'h0); drive(1'b1, 4'h0); drive(1'b1, 4'h1); drive(1'b1, 4'h2);
    drive(1'b0, 4'hF); ac = last_drv;
    idle(4);
    n_checks++; if (abort_q.size() != 1 || abort_q[0] != ac)
      $display("FAIL abort_pulse: got n=%0d cyc=%0d want n=1 cyc=%0d", abort_q.size(), (abort_q.size() > 0) ? abort_q[0] : -1, ac); else n_pass++;
    n_checks++; if (rec_q.size() != 0) $display("FAIL abort_no_valid: got %0d want 0", rec_q.size()); else n_pass++;
`ifdef LPC_ABORT_COUNT_EN
    n_checks++; if (out_abort_cnt !== 16'd1) $display("FAIL abort_cnt: got %0d want 1", out_abort_cnt); else n_pass++;
`endif
  endtask

  task automatic test_timeout();
    int ac, dc; rec_t r;
    rec_q.delete(); abort_q.delete();
    drive(1'b0, 4'h0); drive(1'b1, 4'h2);
    for (int n = 3; n >= 0; n--) drive(1'b1, 4'(n));
    drive(1'b1, 4'h1); drive(1'b1, 4'h2); idle(2);
    repeat (TMO + 1) drive(1'b1, 4'h6);
    ac = last_drv;
    repeat (3) drive(1'b1, 4'h6);
    idle(2);
    n_checks++; if (abort_q.size() != 1 || abort_q[0] != ac)
      $display("FAIL timeout_abort: got n=%0d cyc=%0d want n=1 cyc=%0d", abort_q.size(), (abort_q.size() > 0) ? abort_q[0] : -1, ac); else n_pass++;
    n_checks++; if (rec_q.size() != 0) $display("FAIL timeout_no_valid: got %0d want 0", rec_q.size()); else n_pass++;
    run_cycle(1'b1, 1'b1, 32'h03F8, 8'h41, TMO, 4'h6, 4'h9, dc);
    idle(3);
    if (rec_q.size() > 0) r = rec_q[0];
    n_checks++; if (rec_q.size() != 1 || got_rec(r) !== exp_rec(1'b1, 1'b1, 32'h03F8, 8'h41, 4'h9))
      $display("FAIL timeout_recover: got n=%0d %h want n=1 %h", rec_q.size(), got_rec(r), exp_rec(1'b1, 1'b1, 32'h03F8, 8'h41, 4'h9)); else n_pass++;
  endtask

  task automatic test_dma();
    int dc; rec_t r;
    rec_q.delete(); abort_q.delete();
    drive(1'b0, 4'h0); drive(1'b1, 4'h8);
    repeat (12) drive(1'b1, 4'($urandom));
    drive(1'b0, 4'hF);
    idle(3);
    n_checks++; if (rec_q.size() + abort_q.size() != 0)
      $display("FAIL dma_ignored: got %0d events want 0", rec_q.size() + abort_q.size()); else n_pass++;
    run_cycle(1'b1, 1'b0, 32'h0070, 8'h9E, 1, 4'h5, 4'h0, dc);
    idle(3);
    if (rec_q.size() > 0) r = rec_q[0];
    n_checks++; if (rec_q.size() != 1 || got_rec(r) !== exp_rec(1'b1, 1'b0, 32'h0070, 8'h9E, 4'h0))
      $display("FAIL dma_recover: got n=%0d %h want n=1 %h", rec_q.size(), got_rec(r), exp_rec(1'b1, 1'b0, 32'h0070, 8'h9E, 4'h0)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    rec_q.delete(); abort_q.delete();
    run_cycle(1'b1, 1'b1, 32'h1234, 8'hA5, 0, 4'h6, 4'h0, d1);
    idle(1);
    run_cycle(1'b0, 1'b0, 32'h8765_4321, 8'h3C, 2, 4'h6, 4'hA, d2);
    idle(3);
    n_checks++; if (rec_q.size() != 2) $display("FAIL b2b_count: got %0d want 2", rec_q.size()); else n_pass++;
    if (rec_q.size() == 2) begin
      n_checks++; if (got_rec(rec_q[0]) !== exp_rec(1'b1, 1'b1, 32'h1234, 8'hA5, 4'h0) || rec_q[0].cyc != d1)
        $display("FAIL b2b_first: got %h@%0d want %h@%0d", got_rec(rec_q[0]), rec_q[0].cyc, exp_rec(1'b1, 1'b1, 32'h1234, 8'hA5, 4'h0), d1); else n_pass++;
      n_checks++; if (got_rec(rec_q[1]) !== exp_rec(1'b0, 1'b0, 32'h8765_4321, 8'h3C, 4'hA) || rec_q[1].cyc != d2)
        $display("FAIL b2b_second: got %h@%0d want %h@%0d", got_rec(rec_q[1]), rec_q[1].cyc, exp_rec(1'b0, 1'b0, 32'h8765_4321, 8'h3C, 4'hA), d2); else n_pass++;
    end
  endtask

  task automatic test_random();
    bit io, wr; logic [31:0] a; logic [7:0] d; int w, dc; logic [3:0] rc, wc;
    logic [3:0] rcodes [3];
    rcodes[0] = 4'h0; rcodes[1] = 4'h9; rcodes[2] = 4'hA;
    for (int i = 0; i < 16; i++) begin
      rec_q.delete(); abort_q.delete();
      io = 1'($urandom); wr = 1'($urandom); a = $urandom; d = 8'($urandom);
      w  = int'($urandom_range(0, TMO));
      rc = rcodes[$urandom_range(0, 2)];
      wc = $urandom_range(0, 1) ? 4'h5 : 4'h6;
      run_cycle(io, wr, a, d, w, wc, rc, dc);
      idle(2);
      n_checks++; if (rec_q.size() != 1 || abort_q.size() != 0)
        $display("FAIL rand%0d_events: got rec=%0d abort=%0d want 1/0", i, rec_q.size(), abort_q.size()); else n_pass++;
      if (rec_q.size() > 0) begin
        n_checks++; if (got_rec(rec_q[0]) !== exp_rec(io, wr, a, d, rc) || rec_q[0].cyc != dc)
          $display("FAIL rand%0d_rec: got %h@%0d want %h@%0d", i, got_rec(rec_q[0]), rec_q[0].cyc, exp_rec(io, wr, a, d, rc), dc); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int dc; rec_t r;
    run_cycle(1'b1, 1'b1, 32'h02E8, 8'h77, 0, 4'h6, 4'h0, dc);
    idle(3);
    drive(1'b0, 4'h0); drive(1'b1, 4'h6); drive(1'b1, 4'hF); drive(1'b1, 4'hF);
    @(negedge lpc_clk);
    lpc_reset = 1'b1;
    #1;
    n_checks++; if ({out_valid, out_abort, out_mode, out_direction, out_sync_err, out_addr, out_data} !== '0)
      $display("FAIL reset_mid_outputs: got mode=%b dir=%b addr=%h data=%h want 0", out_mode, out_direction, out_addr, out_data); else n_pass++;
`ifdef LPC_ABORT_COUNT_EN
    n_checks++; if (out_abort_cnt !== 16'd0) $display("FAIL reset_mid_cnt: got %0d want 0", out_abort_cnt); else n_pass++;
`endif
    repeat (2) @(negedge lpc_clk);
    lpc_reset = 1'b0;
    rec_q.delete(); abort_q.delete();
    repeat (6) drive(1'b1, 4'($urandom));
    run_cycle(1'b0, 1'b1, 32'hFED0_0010, 8'h12, 2, 4'h5, 4'h9, dc);
    idle(3);
    if (rec_q.size() > 0) r = rec_q[0];
    n_checks++; if (rec_q.size() != 1 || abort_q.size() != 0 || got_rec(r) !== exp_rec(1'b0, 1'b1, 32'hFED0_0010, 8'h12, 4'h9))
      $display("FAIL reset_mid_recover: got n=%0d %h want n=1 %h", rec_q.size(), got_rec(r), exp_rec(1'b0, 1'b1, 32'hFED0_0010, 8'h12, 4'h9)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_io_write();
    test_mem_read();
    test_sync_err();
    test_abort();
    test_timeout();
    test_dma();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_checks++; if (overlap != 0) $display("FAIL valid_abort_overlap: got %0d want 0", overlap); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lpc_cycle_decoder.md
Name: lpc_cycle_decoder

Overview:
- Passive LPC bus sniffer/decoder. Tracks host-initiated I/O and memory cycles, read and write, on LAD[3:0]/LFRAME#.
- Handles SYNC wait states, error SYNC, host abort and restart.
- Presents each completed cycle as a one-clock record (mode, direction, address, data) to downstream capture/UART logic.
- Sits directly on the LPC pins, in the lpc_clk domain.

Parameters:
- ADDR_WIDTH, 32: width of out_addr. Legal range 16..32. I/O addresses are zero-extended. Memory addresses are truncated to the low ADDR_WIDTH bits.
- ENABLE_MEM, 1: when 0, memory cycles are treated as unsupported.
- SYNC_TIMEOUT, 32: maximum number of consecutive wait SYNC nibbles before the cycle is abandoned. 0 disables the timeout. Wait counter is 8 bits wide.

Ports:
- lpc_clk, input, 1: LPC clock (33 MHz).
- lpc_reset, input, 1: asynchronous, active-high reset.
- lpc_frame_n, input, 1: LFRAME#, active low.
- lpc_ad, input, 4: LAD[3:0].
- out_valid, output, 1: one-clock pulse; record fields are valid in this cycle.
- out_mode, output, 1: 1 = I/O, 0 = memory.
- out_direction, output, 1: 1 = write, 0 = read.
- out_addr, output, ADDR_WIDTH: cycle address.
- out_data, output, 8: data byte.
- out_sync_err, output, 1: SYNC was 1010 for this record; qualified by out_valid.
- out_abort, output, 1: one-clock pulse when an in-progress cycle is abandoned.

Behaviour:
- Reset: lpc_reset=1 forces state IDLE and clears all outputs and internal counters to 0, at any time including mid-cycle.
- All LAD sampling happens on posedge lpc_clk.

Start and abort rules (apply in every state):
- lpc_frame_n=0 and lpc_ad=0000 → go to START. A cycle in progress is dropped without out_abort.
- lpc_frame_n=0 and lpc_ad=1111 → go to IDLE. Pulse out_abort if state was not IDLE/IGNORE.
- lpc_frame_n=0 with any other lpc_ad → go to IDLE.

States:
- IDLE: wait for a start condition.
- START: stay here while lpc_frame_n=0 and lpc_ad=0000. On the first clock with lpc_frame_n=1, decode lpc_ad as CYCTYPE/DIR:
  - bits[3:2]=00 → I/O: mode=1, direction=lpc_ad[1], 4 address nibbles.
  - bits[3:2]=01 with ENABLE_MEM=1 → memory: mode=0, direction=lpc_ad[1], 8 address nibbles.
  - anything else (DMA, reserved, or memory with ENABLE_MEM=0) → IGNORE.
- ADDR: shift in nibbles MSN first, one per clock. Then go to WDATA if write, else TAR1.
- WDATA: 2 clocks; low nibble first → data[3:0], then data[7:4]. Then go to TAR1.
- TAR1: exactly 2 clocks, LAD ignored. Then go to SYNC.
- SYNC: sample one nibble per clock.
  - 0000 or 1001 → ready, sync_err=0.
  - 1010 → ready, sync_err=1.
  - 0101 or 0110 → wait; increment wait counter. When the count exceeds SYNC_TIMEOUT (nonzero), pulse out_abort and go to IGNORE.
  - any other value → pulse out_abort, go to IGNORE.
  - On ready: a write goes to DONE; a read goes to RDATA.
- RDATA: 2 clocks, low nibble first. Then go to DONE.
- DONE: record complete; go to TAR2.
- TAR2: 2 clocks, then IDLE. A start condition during TAR2 is honoured (back-to-back cycles).
- IGNORE: wait for the next lpc_frame_n=0 start condition.

Record output:
- out_valid pulses exactly one clock, registered in the clock after the completing sample:
  - write: the clock after the ready SYNC is sampled;
  - read: the clock after the second data nibble is sampled.
- out_mode, out_direction, out_addr, out_data and out_sync_err update in the same clock as out_valid and hold until the next record.
- out_abort and out_valid are never high in the same clock.

Optional Feature:
- Macro: LPC_ABORT_COUNT_EN.
- Defined: adds output out_abort_cnt (16 bits).
  - Reset value 0.
  - Increments on every out_abort pulse; saturates at 0xFFFF.
  - Clears on lpc_reset only.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- I/O write: START, CYCTYPE 0010, addr 0,0,8,0, data nibbles A then 5, 2 TAR clocks, SYNC 0000 → one out_valid with mode=1, dir=1, addr=0x0080, data=0x5A, sync_err=0.
- Memory read: CYCTYPE 0100, addr FFFF_FFF0, SYNC 0101×3 then 0000, data 3,C → out_valid with mode=0, dir=0, addr=0xFFFFFFF0, data=0xC3, asserted 1 clock after the C nibble.
- Error SYNC on I/O read of port 0x0060: SYNC 1010, data 0xFF → out_valid with sync_err=1, data=0xFF.
- Abort: lpc_frame_n=0 with LAD=1111 after the second address nibble → out_abort 1 clock, no out_valid. With LPC_ABORT_COUNT_EN defined, out_abort_cnt=1.
- SYNC_TIMEOUT=4: send 5 consecutive 0110 → out_abort on the 5th; the following start condition decodes a normal I/O write correctly.
- Robustness: a DMA CYCTYPE 1000 → no outputs until the next START. Asserting lpc_reset mid-ADDR → all outputs 0 and state IDLE, and a new cycle decodes correctly.
